// File: rtl/branch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mini_src_ctrl_pkg
// Description : Shared state encoding, ALU codes, branch conditions and
//               opcodes for the Mini SRC control sequencer.
// Revision    : 1.0
// ============================================================================
package mini_src_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd7,
        ST_T1   = 4'd8,
        ST_T2   = 4'd9,
        ST_T3   = 4'd10,
        ST_T4   = 4'd11,
        ST_T5   = 4'd12,
        ST_T6   = 4'd13
    } state_t;

    localparam logic [4:0] C_ALU_NOP = 5'b00000;
    localparam logic [4:0] C_ALU_ADD = 5'b00011;

    localparam logic [1:0] C_COND_ZERO    = 2'b00;
    localparam logic [1:0] C_COND_NONZERO = 2'b01;
    localparam logic [1:0] C_COND_NONNEG  = 2'b10;
    localparam logic [1:0] C_COND_NEG     = 2'b11;

    localparam logic [4:0] C_OP_BR = 5'b10010;

endpackage
`default_nettype wire

// File: rtl/branch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : branch_sequencer_if
// Description : Control/handshake bundle between the sequencer (master) and
//               the datapath/memory side (slave).
// Revision    : 1.0
// ============================================================================
interface branch_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ALU_OP_W   = 5
) ();

    logic                  start;
    logic                  mem_ready;
    logic [4:0]            ir_opcode;
    logic [1:0]            ir_cond;
    logic [DATA_WIDTH-1:0] bus_data;

    logic Pout, MARen, Read, MDRen, MDROut, IRen, Gra, Rout;
    logic ConIn, Yen, Cout, Zen, ZLOout, Pen;
    logic [ALU_OP_W-1:0]   alu_control;
    logic busy, done, illegal, mem_err, branch_taken;

    modport master (
        input  start, mem_ready, ir_opcode, ir_cond, bus_data,
        output Pout, MARen, Read, MDRen, MDROut, IRen, Gra, Rout,
        output ConIn, Yen, Cout, Zen, ZLOout, Pen, alu_control,
        output busy, done, illegal, mem_err, branch_taken
    );

    modport slave (
        output start, mem_ready, ir_opcode, ir_cond, bus_data,
        input  Pout, MARen, Read, MDRen, MDROut, IRen, Gra, Rout,
        input  ConIn, Yen, Cout, Zen, ZLOout, Pen, alu_control,
        input  busy, done, illegal, mem_err, branch_taken
    );

endinterface
`default_nettype wire

// File: rtl/branch_sequencer_con_ff.sv
`default_nettype none
// ============================================================================
// Module      : con_ff
// Description : Branch condition evaluator and CON flip-flop.
// Revision    : 1.0
// ============================================================================
module con_ff
    import mini_src_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire                  clk,
    input  wire                  clr,
    input  wire                  ConIn,
    input  wire [1:0]            ir_cond,
    input  wire [DATA_WIDTH-1:0] bus_data,
    output logic                 branch_taken
);

    logic w_cond;
    logic r_con;

    always_comb begin
        w_cond = 1'b0;
        case (ir_cond)
            C_COND_ZERO:    w_cond = (bus_data == '0);
            C_COND_NONZERO: w_cond = (bus_data != '0);
            C_COND_NONNEG:  w_cond = ~bus_data[DATA_WIDTH-1];
            C_COND_NEG:     w_cond =  bus_data[DATA_WIDTH-1];
            default:        w_cond = 1'b0;
        endcase
    end

    // Holds the last evaluated condition until the next ConIn step.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_con <= 1'b0;
        end else if (ConIn) begin
            r_con <= w_cond;
        end
    end

    assign branch_taken = r_con;

endmodule
`default_nettype wire

// File: rtl/branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : branch_sequencer
// Description : Mini SRC fetch (T0-T2) and conditional-branch (T3-T6) step
//               sequencer. Macro BRANCH_SEQ_MEM_WAIT_EN adds T1 memory wait
//               with timeout/mem_err.
// Revision    : 1.0
// ============================================================================
module branch_sequencer
    import mini_src_ctrl_pkg::*;
#(
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  ALU_OP_W    = 5,
    parameter logic [ALU_OP_W-1:0] ALU_ADD     = ALU_OP_W'(C_ALU_ADD),
    parameter logic [4:0]          BR_OPCODE   = C_OP_BR,
    parameter int                  MEM_TIMEOUT = 15
) (
    input wire                 clk,
    input wire                 clr,
    branch_sequencer_if.master bus
);

    state_t r_state;
    state_t w_next;
    logic   w_t1_done;
    logic   w_timeout;
    logic   w_taken;

`ifdef BRANCH_SEQ_MEM_WAIT_EN
    logic [7:0] r_wait_cnt;

    // Counter idles at zero outside T1, so it is cleared on every T1 entry.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state != ST_T1) begin
            r_wait_cnt <= 8'd0;
        end else if (!bus.mem_ready && (r_wait_cnt != 8'hFF)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign w_t1_done = bus.mem_ready;
    assign w_timeout = !bus.mem_ready && (r_wait_cnt == 8'(MEM_TIMEOUT));
`else
    logic       w_unused_mem_ready;
    logic [7:0] w_unused_tmo;

    assign w_unused_mem_ready = bus.mem_ready;
    assign w_unused_tmo       = 8'(MEM_TIMEOUT);
    assign w_t1_done          = 1'b1;
    assign w_timeout          = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        bus.Pout        = 1'b0;
        bus.MARen       = 1'b0;
        bus.Read        = 1'b0;
        bus.MDRen       = 1'b0;
        bus.MDROut      = 1'b0;
        bus.IRen        = 1'b0;
        bus.Gra         = 1'b0;
        bus.Rout        = 1'b0;
        bus.ConIn       = 1'b0;
        bus.Yen         = 1'b0;
        bus.Cout        = 1'b0;
        bus.Zen         = 1'b0;
        bus.ZLOout      = 1'b0;
        bus.Pen         = 1'b0;
        bus.alu_control = ALU_OP_W'(C_ALU_NOP);
        bus.done        = 1'b0;
        bus.illegal     = 1'b0;
        bus.mem_err     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = ST_T0;
            end
            ST_T0: begin
                bus.Pout  = 1'b1;
                bus.MARen = 1'b1;
                w_next    = ST_T1;
            end
            ST_T1: begin
                bus.Read  = 1'b1;
                bus.MDRen = 1'b1;
                // A ready memory in the timeout cycle still completes the read.
                if (w_t1_done) begin
                    w_next = ST_T2;
                end else if (w_timeout) begin
                    bus.mem_err = 1'b1;
                    w_next      = ST_IDLE;
                end
            end
            ST_T2: begin
                bus.MDROut = 1'b1;
                bus.IRen   = 1'b1;
                if (bus.ir_opcode == BR_OPCODE) begin
                    w_next = ST_T3;
                end else begin
                    bus.illegal = 1'b1;
                    w_next      = ST_IDLE;
                end
            end
            ST_T3: begin
                bus.Gra   = 1'b1;
                bus.Rout  = 1'b1;
                bus.ConIn = 1'b1;
                w_next    = ST_T4;
            end
            ST_T4: begin
                bus.Pout = 1'b1;
                bus.Yen  = 1'b1;
                w_next   = ST_T5;
            end
            ST_T5: begin
                bus.Cout        = 1'b1;
                bus.Zen         = 1'b1;
                bus.alu_control = ALU_ADD;
                w_next          = ST_T6;
            end
            ST_T6: begin
                bus.ZLOout = 1'b1;
                bus.Pen    = w_taken;
                bus.done   = 1'b1;
                w_next     = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.branch_taken = w_taken;

    con_ff #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_con_ff (
        .clk          (clk),
        .clr          (clr),
        .ConIn        (bus.ConIn),
        .ir_cond      (bus.ir_cond),
        .bus_data     (bus.bus_data),
        .branch_taken (w_taken)
    );

endmodule
`default_nettype wire

// File: tb/tb_branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_sequencer
// Description : Directed scoreboard bench for branch_sequencer.
// Revision    : 1.0
// ============================================================================
module tb_branch_sequencer;

    localparam logic [4:0] BR  = 5'b10010;
    localparam logic [4:0] ADD = 5'b00011;
`ifdef BRANCH_SEQ_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef struct packed {
        int busy; int rd; int dn; int il; int er; int pen;
        int zlo; int conin; int yen; int add; int stray; int taken;
    } res_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_con     = 0;
    res_t sb[$];

    branch_sequencer_if #(.DATA_WIDTH(32), .ALU_OP_W(5)) bus_if ();

    branch_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cond_ok(input logic [1:0] c, input logic [31:0] d);
        case (c)
            2'b00:   return (d == 32'd0) ? 1 : 0;
            2'b01:   return (d != 32'd0) ? 1 : 0;
            2'b10:   return d[31] ? 0 : 1;
            default: return d[31] ? 1 : 0;
        endcase
    endfunction

    function automatic int all_outs();
        return int'({bus_if.Pout, bus_if.MARen, bus_if.Read, bus_if.MDRen, bus_if.MDROut,
                     bus_if.IRen, bus_if.Gra, bus_if.Rout, bus_if.ConIn, bus_if.Yen,
                     bus_if.Cout, bus_if.Zen, bus_if.ZLOout, bus_if.Pen, bus_if.busy,
                     bus_if.done, bus_if.illegal, bus_if.mem_err, bus_if.branch_taken,
                     bus_if.alu_control});
    endfunction

    // Expected outcome of one sequence; waits < 0 means memory never ready.
    task automatic push_expected(input logic [4:0] op, input logic [1:0] cond,
                                 input logic [31:0] data, input int waits);
        res_t e;
        bit   tmo;
        int   t1;
        e   = '0;
        tmo = WAIT_EN && (waits < 0);
        t1  = !WAIT_EN ? 1 : (tmo ? 16 : waits + 1);
        e.rd = t1;
        if (tmo) begin
            e.busy = 1 + t1;
            e.er   = 1;
        end else if (op != BR) begin
            e.busy = t1 + 2;
            e.il   = 1;
        end else begin
            exp_con = cond_ok(cond, data);
            e.busy  = t1 + 6;
            e.dn    = 1;
            e.pen   = exp_con;
            e.zlo   = 1;
            e.conin = 1;
            e.yen   = 1;
            e.add   = 1;
        end
        e.taken = exp_con;
        sb.push_back(e);
    endtask

    task automatic run_seq(input string name, input logic [4:0] op, input logic [1:0] cond,
                           input logic [31:0] data, input int waits);
        res_t o, e;
        int   cyc;
        bit   seen;
        o = '0; cyc = 0; seen = 1'b0;
        push_expected(op, cond, data, waits);
        @(negedge clk);
        bus_if.ir_opcode = op;
        bus_if.ir_cond   = cond;
        bus_if.bus_data  = data;
        bus_if.mem_ready = 1'b0;
        bus_if.start     = 1'b1;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            bus_if.start = 1'b0;
            if (!bus_if.busy && seen) break;
            if (bus_if.busy) begin seen = 1'b1; o.busy++; end
            if (bus_if.Read) o.rd++;
            o.dn += int'(bus_if.done);
            o.il += int'(bus_if.illegal);
            o.er += int'(bus_if.mem_err);
            o.conin += int'(bus_if.ConIn);
            o.yen += int'(bus_if.Yen);
            if (bus_if.Zen && bus_if.alu_control == ADD) o.add++;
            if (!bus_if.Zen && bus_if.alu_control != 5'd0) o.stray++;
            if (bus_if.done) begin
                o.pen = int'(bus_if.Pen);
                o.zlo = int'(bus_if.ZLOout);
            end
            bus_if.mem_ready = (waits >= 0) && (o.rd > waits);
        end
        o.taken = int'(bus_if.branch_taken);
        chk({name, ".bounded"}, int'(cyc < 60), 1);
        e = sb.pop_front();
        chk({name, ".busy"},    o.busy,  e.busy);
        chk({name, ".read"},    o.rd,    e.rd);
        chk({name, ".done"},    o.dn,    e.dn);
        chk({name, ".illegal"}, o.il,    e.il);
        chk({name, ".mem_err"}, o.er,    e.er);
        chk({name, ".pen"},     o.pen,   e.pen);
        chk({name, ".zlo"},     o.zlo,   e.zlo);
        chk({name, ".conin"},   o.conin, e.conin);
        chk({name, ".yen"},     o.yen,   e.yen);
        chk({name, ".alu_add"}, o.add,   e.add);
        chk({name, ".alu_0"},   o.stray, e.stray);
        chk({name, ".taken"},   o.taken, e.taken);
    endtask

    initial begin
        int cyc;
        int busy_n;
        int done_n;
        bus_if.start     = 1'b0;
        bus_if.mem_ready = 1'b0;
        bus_if.ir_opcode = 5'd0;
        bus_if.ir_cond   = 2'd0;
        bus_if.bus_data  = 32'd0;

        // Reset state
        #2 clr = 1'b0;
        #1 chk("reset.outs", all_outs(), 0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("reset.idle", all_outs(), 0);

        run_seq("brzr_0",     BR,    2'b00, 32'h0000_0000, 0);
        run_seq("brnz_0",     BR,    2'b01, 32'h0000_0000, 0);
        run_seq("brmi_msb",   BR,    2'b11, 32'h8000_0000, 0);
        run_seq("brmi_one",   BR,    2'b11, 32'h0000_0001, 0);
        run_seq("brpl_0",     BR,    2'b10, 32'h0000_0000, 0);
        run_seq("brnz_10",    BR,    2'b01, 32'h0000_0010, 0);
        run_seq("wait3",      BR,    2'b00, 32'h0000_0000, 3);
        run_seq("no_ready",   BR,    2'b01, 32'h0000_0000, -1);
        run_seq("illegal",    5'b00011, 2'b00, 32'h0000_0000, 0);

        // Reset during T4 of a taken branch
        push_expected(BR, 2'b00, 32'h0, 0);
        void'(sb.pop_front());
        @(negedge clk);
        bus_if.ir_opcode = BR;
        bus_if.ir_cond   = 2'b00;
        bus_if.bus_data  = 32'h0;
        bus_if.mem_ready = 1'b1;
        bus_if.start     = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            bus_if.start = 1'b0;
            cyc++;
        end while (!bus_if.Yen && cyc < 20);
        chk("rst_mid.reach_t4", int'(bus_if.Yen), 1);
        chk("rst_mid.con_before", int'(bus_if.branch_taken), 1);
        #2 clr = 1'b0;
        #1 chk("rst_mid.outs", all_outs(), 0);
        exp_con = 0;
        done_n = 0;
        repeat (3) begin
            @(negedge clk);
            done_n += int'(bus_if.done);
        end
        chk("rst_mid.no_done", done_n, 0);
        clr = 1'b1;
        run_seq("after_rst", BR, 2'b01, 32'h0000_0005, 0);

        // start held high: back-to-back sequences with one IDLE cycle between
        @(negedge clk);
        bus_if.ir_opcode = BR;
        bus_if.ir_cond   = 2'b00;
        bus_if.bus_data  = 32'h0;
        bus_if.mem_ready = 1'b1;
        bus_if.start     = 1'b1;
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            busy_n += int'(bus_if.busy);
            done_n += int'(bus_if.done);
        end
        bus_if.start = 1'b0;
        chk("held.busy", busy_n, 14);
        chk("held.done", done_n, 2);
        @(negedge clk);
        chk("held.idle", int'(bus_if.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_sequencer.md
# branch_sequencer

Parametrised control-step sequencer for the Mini SRC datapath. It drives the datapath strobes for instruction fetch (T0–T2) and the conditional-branch execute steps (T3–T6). It contains the CON FF and uses the latched condition to gate the PC load in T6. It sits between the system clock/reset and the `DataPath` control inputs, and replaces hand-driven step sequences with a reusable, memory-handshaked FSM.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of the bus sampled by the CON FF.
- `ALU_OP_W`, 5, width of `alu_control`.
- `ALU_ADD`, 5'b00011, ALU code driven in T5 (PC + C).
- `BR_OPCODE`, 5'b10010, IR opcode that selects the branch execute path.
- `MEM_TIMEOUT`, 15, maximum T1 wait cycles before abort. Range 1..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `clr` in 1: asynchronous, active-low reset.
- `start` in 1: begin one fetch/branch sequence. Sampled only in IDLE.
- `mem_ready` in 1: memory read data valid.
- `ir_opcode` in 5: IR[31:27].
- `ir_cond` in 2: IR[20:19]. Encodings: 00 zero, 01 nonzero, 10 non-negative, 11 negative.
- `bus_data` in `DATA_WIDTH`: datapath bus, evaluated in T3.
- `Pout`, `MARen`, `Read`, `MDRen`, `MDROut`, `IRen`, `Gra`, `Rout`, `ConIn`, `Yen`, `Cout`, `Zen`, `ZLOout`, `Pen` out 1: datapath strobes.
- `alu_control` out `ALU_OP_W`: ALU operation select.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on completion.
- `illegal` out 1: one-cycle pulse when the opcode is not `BR_OPCODE`.
- `mem_err` out 1: one-cycle pulse on T1 timeout.
- `branch_taken` out 1: CON FF value.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. State register is 4-bit. Strobes are a Moore decode of the state.
- IDLE: all strobes low. On `start`=1, go to T0.
- T0: `Pout`, `MARen`. Go to T1.
- T1: `Read`, `MDRen`. Go to T2 when `mem_ready`=1 (see Configuration).
- T2: `MDROut`, `IRen`. If `ir_opcode`==`BR_OPCODE`, go to T3. Otherwise assert `illegal` and go to IDLE.
- T3: `Gra`, `Rout`, `ConIn`. The CON FF loads cond(`ir_cond`, `bus_data`) at the end of T3:
  - 00: bus==0
  - 01: bus!=0
  - 10: MSB==0
  - 11: MSB==1
- T4: `Pout`, `Yen`.
- T5: `Cout`, `Zen`, `alu_control`=`ALU_ADD`. `alu_control` is 0 in every other state.
- T6: `ZLOout`=1, `Pen`=`branch_taken`, `done`=1. Go to IDLE.
- The CON FF holds its value until the next T3 or reset.
- `start` outside IDLE is ignored. `start` held high in IDLE begins the next sequence immediately.
- Reset (`clr`=0) at any point, including mid-sequence:
  - state goes to IDLE immediately (asynchronous)
  - CON FF cleared
  - all outputs 0
  - no `done` is generated for the aborted sequence.

## Timing
- `start` sampled high at edge k gives T0 in cycle k+1. With zero wait states, T6 falls in cycle k+7 and IDLE in k+8.
- Each state except T1 lasts exactly one cycle. T1 lasts 1 + n cycles, where n is the number of cycles `mem_ready` is low in T1.
- `done`, `illegal` and `mem_err` are single-cycle pulses and mutually exclusive.
- Outputs change only after the rising edge of `clk`, except on asynchronous reset.
- T1 counter: 8-bit, cleared on entry to T1. The timeout fires when the counter equals `MEM_TIMEOUT` with `mem_ready` still low. `mem_ready` in that same cycle wins over the timeout.

## Configuration
- `BRANCH_SEQ_MEM_WAIT_EN` defined:
  - T1 waits on `mem_ready`.
  - The timeout counter and `mem_err` are present.
- `BRANCH_SEQ_MEM_WAIT_EN` undefined:
  - T1 is one cycle and `mem_ready` is ignored.
  - No counter; `mem_err` is tied to 0.

## Structure
- Package `mini_src_ctrl_pkg` holds:
  - the state enum/constants (IDLE=0, T0..T6 = 7..13)
  - ALU op codes
  - branch condition encodings
  - opcode constants.
- Sub-module `con_ff`: condition evaluator plus the flop. Inputs are `clk`, `clr`, `ConIn`, `ir_cond`, `bus_data`; output is `branch_taken`.

## Test plan
- brzr (cond 00), `bus_data`=0, `mem_ready` tied 1 → `busy` for 7 cycles; `Pen`=1 and `done`=1 in T6; `branch_taken`=1.
- brnz (cond 01), `bus_data`=0 → `Pen`=0 in T6, `ZLOout`=1, `done` pulse.
- brmi (cond 11), `bus_data`=32'h8000_0000 → taken. Same with 32'h0000_0001 → not taken. brpl (cond 10) on 0 → taken.
- `mem_ready` low for 3 cycles in T1 → `Read`/`MDRen` high for 4 cycles; total sequence 10 cycles. `mem_ready` never asserted → `mem_err` pulse after 16 T1 cycles, then IDLE.
- `ir_opcode`=5'b00011 → `illegal` pulse in T2; no T3–T6 strobes; `busy` low next cycle.
- `clr` low during T4 → all outputs 0 and `branch_taken`=0 immediately; no `done`. New `start` after release runs normally from T0.
